stack_ctrl: RTL and testbench

- LIFO sequencer for the 32x32 single-port synchronous RAM block. It turns it into a hardware stack.
- Accepts push/pop commands, maintains the stack pointer, and drives the RAM address, write-enable and write-data.
- Captures read data and flags overflow and underflow.
- Sits between the board switch/command logic and the RAM instance; the RAM itself lives outside the block.

---
 rtl/stack_pkg.sv | 10 +
 rtl/stack_ptr.sv | 41 ++++
 rtl/stack_ctrl.sv | 117 +++++++++++
 tb/tb_stack_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and default widths for the hardware stack controller.
package stack_pkg;
   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_e;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
endpackage

// File: rtl/stack_ptr.sv
// Stack pointer register; sp doubles as the entry count and never wraps.
module stack_ptr
   import stack_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   input  logic            inc_i,
   input  logic            dec_i,
   output logic [ADDR_W:0] sp_o,
   output logic            full_o,
   output logic            empty_o
);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W:0] sp_q, sp_d;

   always_comb begin
      sp_d = sp_q;
      if (clr_i)
         sp_d = '0;
      else if (dec_i)
         sp_d = sp_q - 1'b1;
      else if (inc_i)
         sp_d = sp_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         sp_q <= '0;
      else
         sp_q <= sp_d;
   end

   assign sp_o    = sp_q;
   assign full_o  = (sp_q == FULL_CNT);
   assign empty_o = (sp_q == '0);
endmodule

// File: rtl/stack_ctrl.sv
// LIFO sequencer driving an external 1-cycle-latency single-port RAM.
// Optional STACK_PEEK_EN adds a non-destructive read of the top entry.
module stack_ctrl
   import stack_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
`ifdef STACK_PEEK_EN
   input  logic              peek,
`endif
   input  logic [DATA_W-1:0] push_data,
   output logic              cmd_ready,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              ovf_err,
   output logic              unf_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   state_e            state_q, state_d;
   logic [DATA_W-1:0] pop_data_q, pop_data_d;
   logic              pop_valid_q, pop_valid_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [ADDR_W:0]   sp, sp_m1;
   logic              peek_req;
   logic              live, pop_go, peek_go, rd_go, push_go;
   logic              ovf_set, unf_set;

`ifdef STACK_PEEK_EN
   assign peek_req = peek;
`else
   assign peek_req = 1'b0;
`endif

   // Commands only count in IDLE and when not overridden by clear
   assign live    = (state_q == IDLE) & ~clear;
   assign pop_go  = live & pop & ~empty;
   assign peek_go = live & ~pop & peek_req & ~empty;
   assign rd_go   = pop_go | peek_go;
   assign push_go = live & push & ~full & ~rd_go;
   assign unf_set = live & (pop | peek_req) & empty;
   assign ovf_set = live & push & full & ~rd_go;

   stack_ptr #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ptr (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (clear),
      .inc_i   (push_go),
      .dec_i   (pop_go),
      .sp_o    (sp),
      .full_o  (full),
      .empty_o (empty)
   );

   assign sp_m1     = sp - 1'b1;
   assign ram_we    = push_go;
   assign ram_wdata = push_data;
   assign ram_addr  = rd_go ? sp_m1[ADDR_W-1:0] : sp[ADDR_W-1:0];

   always_comb begin
      state_d     = state_q;
      pop_valid_d = 1'b0;
      pop_data_d  = pop_data_q;
      ovf_d       = ovf_q | ovf_set;
      unf_d       = unf_q | unf_set;
      if (clear) begin
         state_d = IDLE;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end else if (state_q == RD_WAIT) begin
         state_d     = IDLE;
         pop_valid_d = 1'b1;
         pop_data_d  = ram_rdata;
      end else if (rd_go) begin
         state_d = RD_WAIT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign pop_data  = pop_data_q;
   assign pop_valid = pop_valid_q;
   assign count     = sp;
   assign ovf_err   = ovf_q;
   assign unf_err   = unf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural 32x32 sync RAM.
module tb_stack_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        push = 1'b0;
   logic        pop = 1'b0;
`ifdef STACK_PEEK_EN
   logic        peek = 1'b0;
`endif
   logic [31:0] push_data = '0;
   logic        cmd_ready;
   logic [31:0] pop_data;
   logic        pop_valid;
   logic [5:0]  count;
   logic        full, empty, ovf_err, unf_err;
   logic [4:0]  ram_addr;
   logic        ram_we;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic [31:0] mem [32];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   stack_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .push      (push),
      .pop       (pop),
`ifdef STACK_PEEK_EN
      .peek      (peek),
`endif
      .push_data (push_data),
      .cmd_ready (cmd_ready),
      .pop_data  (pop_data),
      .pop_valid (pop_valid),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .ovf_err   (ovf_err),
      .unf_err   (unf_err),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_chk++;
      if ({cmd_ready, pop_valid, full, empty, ovf_err, unf_err} !== 6'b100100) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 100100",
            {cmd_ready, pop_valid, full, empty, ovf_err, unf_err});
      end
      n_chk++;
      if (count !== 6'd0 || pop_data !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_regs count=%0d pop_data=%h want 0/0", count, pop_data);
      end
   endtask

   task automatic test_push3();
      logic [31:0] v [3];
      v[0] = 32'h11111111; v[1] = 32'h22222222; v[2] = 32'h33333333;
      for (int i = 0; i < 3; i++) begin
         push = 1'b1; push_data = v[i];
         #1;
         n_chk++;
         if (ram_we !== 1'b1 || ram_addr !== 5'(i) || ram_wdata !== v[i]) begin
            n_fail++;
            $display("FAIL push3_ram[%0d] we=%b addr=%0d wd=%h want 1/%0d/%h",
               i, ram_we, ram_addr, ram_wdata, i, v[i]);
         end
         step();
      end
      push = 1'b0;
      #1;
      n_chk++;
      if (count !== 6'd3 || empty !== 1'b0 || ram_we !== 1'b0) begin
         n_fail++;
         $display("FAIL push3_count count=%0d empty=%b we=%b want 3/0/0", count, empty, ram_we);
      end
   endtask

   task automatic test_pop3();
      logic [31:0] v [3];
      v[0] = 32'h33333333; v[1] = 32'h22222222; v[2] = 32'h11111111;
      for (int i = 0; i < 3; i++) begin
         pop = 1'b1;
         #1;
         n_chk++;
         if (ram_addr !== 5'(2 - i) || ram_we !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pop3_addr[%0d] addr=%0d we=%b rdy=%b want %0d/0/1",
               i, ram_addr, ram_we, cmd_ready, 2 - i);
         end
         step();
         pop = 1'b0;
         n_chk++;
         if (cmd_ready !== 1'b0 || pop_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pop3_wait[%0d] rdy=%b pv=%b want 0/0", i, cmd_ready, pop_valid);
         end
         step();
         n_chk++;
         if (pop_valid !== 1'b1 || pop_data !== v[i]) begin
            n_fail++;
            $display("FAIL pop3_data[%0d] pv=%b data=%h want 1/%h", i, pop_valid, pop_data, v[i]);
         end
      end
      step();
      n_chk++;
      if (pop_valid !== 1'b0 || count !== 6'd0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL pop3_end pv=%b count=%0d empty=%b want 0/0/1", pop_valid, count, empty);
      end
   endtask

   task automatic test_full();
      push = 1'b1;
      for (int i = 0; i < 32; i++) begin
         push_data = 32'(i);
         step();
      end
      #1;
      n_chk++;
      if (full !== 1'b1 || count !== 6'd32 || ram_we !== 1'b0) begin
         n_fail++;
         $display("FAIL full_state full=%b count=%0d we=%b want 1/32/0", full, count, ram_we);
      end
      step();
      push = 1'b0;
      n_chk++;
      if (ovf_err !== 1'b1 || count !== 6'd32) begin
         n_fail++;
         $display("FAIL full_ovf ovf=%b count=%0d want 1/32", ovf_err, count);
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
      n_chk++;
      if (ovf_err !== 1'b0 || count !== 6'd0 || empty !== 1'b1) begin
         n_fail++;
         $display("FAIL full_clear ovf=%b count=%0d empty=%b want 0/0/1", ovf_err, count, empty);
      end
   endtask

   task automatic test_underflow();
      pop = 1'b1;
      step();
      pop = 1'b0;
      n_chk++;
      if (unf_err !== 1'b1 || cmd_ready !== 1'b1 || count !== 6'd0) begin
         n_fail++;
         $display("FAIL unf_set unf=%b rdy=%b count=%0d want 1/1/0", unf_err, cmd_ready, count);
      end
      step();
      n_chk++;
      if (pop_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL unf_nopv pv=%b want 0", pop_valid);
      end
      pop = 1'b1; push = 1'b1; push_data = 32'hCAFE0001;
      #1;
      n_chk++;
      if (ram_we !== 1'b1 || ram_addr !== 5'd0) begin
         n_fail++;
         $display("FAIL unf_push we=%b addr=%0d want 1/0", ram_we, ram_addr);
      end
      step();
      pop = 1'b0; push = 1'b0;
      n_chk++;
      if (count !== 6'd1 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL unf_push_cnt count=%0d rdy=%b want 1/1", count, cmd_ready);
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
      n_chk++;
      if (unf_err !== 1'b0 || ovf_err !== 1'b0 || count !== 6'd0) begin
         n_fail++;
         $display("FAIL unf_clear unf=%b ovf=%b count=%0d want 0/0/0", unf_err, ovf_err, count);
      end
   endtask

   task automatic test_push_pop_same();
      push = 1'b1; push_data = 32'h12345678;
      step();
      push_data = 32'hA5A5A5A5;
      step();
      pop = 1'b1; push_data = 32'hFFFF0000;
      #1;
      n_chk++;
      if (ram_we !== 1'b0 || ram_addr !== 5'd1) begin
         n_fail++;
         $display("FAIL pp_ram we=%b addr=%0d want 0/1", ram_we, ram_addr);
      end
      step();
      pop = 1'b0;
      #1;
      n_chk++;
      if (ram_we !== 1'b0 || count !== 6'd1) begin
         n_fail++;
         $display("FAIL pp_wait we=%b count=%0d want 0/1", ram_we, count);
      end
      step();
      push = 1'b0;
      n_chk++;
      if (pop_valid !== 1'b1 || pop_data !== 32'hA5A5A5A5 || count !== 6'd1) begin
         n_fail++;
         $display("FAIL pp_data pv=%b data=%h count=%0d want 1/a5a5a5a5/1",
            pop_valid, pop_data, count);
      end
   endtask

   task automatic test_clear_rd_wait();
      pop = 1'b1;
      step();
      pop = 1'b0; clear = 1'b1;
      step();
      clear = 1'b0;
      n_chk++;
      if (pop_valid !== 1'b0 || count !== 6'd0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_wait pv=%b count=%0d rdy=%b want 0/0/1", pop_valid, count, cmd_ready);
      end
   endtask

   task automatic test_rst_mid_pop();
      push = 1'b1; push_data = 32'h0BADF00D;
      step();
      push = 1'b0; pop = 1'b1;
      step();
      pop = 1'b0;
      rst = 1'b1;
      #1;
      n_chk++;
      if (pop_valid !== 1'b0 || count !== 6'd0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid pv=%b count=%0d rdy=%b want 0/0/1", pop_valid, count, cmd_ready);
      end
      #2;
      rst = 1'b0;
      step();
      n_chk++;
      if (pop_valid !== 1'b0 || count !== 6'd0) begin
         n_fail++;
         $display("FAIL rst_after pv=%b count=%0d want 0/0", pop_valid, count);
      end
   endtask

`ifdef STACK_PEEK_EN
   task automatic test_peek();
      push = 1'b1; push_data = 32'hDEADBEEF;
      step();
      push = 1'b0; peek = 1'b1;
      step();
      peek = 1'b0;
      step();
      n_chk++;
      if (pop_valid !== 1'b1 || pop_data !== 32'hDEADBEEF || count !== 6'd1) begin
         n_fail++;
         $display("FAIL peek pv=%b data=%h count=%0d want 1/deadbeef/1",
            pop_valid, pop_data, count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_push3();
      test_pop3();
      test_full();
      test_underflow();
      test_push_pop_same();
      test_clear_rd_wait();
      test_rst_mid_pop();
`ifdef STACK_PEEK_EN
      test_peek();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
